wb_rr_arbiter: RTL and testbench

Round-robin Wishbone arbiter that places NM bus masters onto a single shared Wishbone master port. It sits directly upstream of the conbus fan-in/decode stage and feeds that stage one master's cycle at a time. Arbitration is per cycle (CYC), not per beat: a granted master keeps the bus until it drops CYC. An optional watchdog terminates stalled beats with ERR.

---
 rtl/wb_rr_arbiter_pkg.sv | 42 ++++
 rtl/wb_rr_arbiter_if.sv | 48 ++++
 rtl/wb_rr_arbiter_pick.sv | 24 ++
 rtl/wb_rr_arbiter.sv | 123 ++++++++++++
 tb/tb_wb_rr_arbiter.sv | 259 +++++++++++++++++++++++++
 5 files changed

// File: rtl/wb_rr_arbiter_pkg.sv
// wb_arb_pkg: shared types and helpers for the round-robin Wishbone arbiter.
// Optional watchdog in the top is enabled with `define WB_ARB_TIMEOUT_EN.
package wb_arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        OWN  = 1'b1
    } arb_state_e;

    // Upper bound on masters; index helpers are sized for it.
    localparam int MAX_NM = 8;
    localparam int IDX_W  = 3;

    // LSB of lane k in a packed bus of w-bit lanes.
    function automatic int lane_lsb(input int k, input int w);
        return k * w;
    endfunction

    // Byte-select width for a data width.
    function automatic int sel_w(input int dw);
        return dw / 8;
    endfunction

    // First requester scanning from last+1 upward, wrapping modulo nm.
    // Returns last unchanged when nothing requests.
    // The scan runs downward so the nearest hit is the final assignment.
    function automatic logic [IDX_W-1:0] rr_next(input logic [MAX_NM-1:0] req,
                                                 input logic [IDX_W-1:0]  last,
                                                 input int                nm);
        logic [IDX_W-1:0] pick;
        int               idx;
        pick = last;
        for (int i = MAX_NM; i >= 1; i--) begin
            if (i <= nm) begin
                idx = (int'(last) + i) % nm;
                if (req[idx]) pick = IDX_W'(idx);
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/wb_rr_arbiter_if.sv
// wb_rr_arbiter_if: bundles the per-master Wishbone ports and the shared
// downstream port. The arbiter uses the slave view; the environment
// (bus masters plus downstream slave) uses the master view.
interface wb_rr_arbiter_if #(
    parameter int NM = 3,
    parameter int AW = 32,
    parameter int DW = 32
);
    localparam int SELW = DW / 8;

    logic [NM-1:0]      m_cyc_i;
    logic [NM-1:0]      m_stb_i;
    logic [NM-1:0]      m_we_i;
    logic [NM*AW-1:0]   m_adr_i;
    logic [NM*DW-1:0]   m_dat_i;
    logic [NM*SELW-1:0] m_sel_i;
    logic [NM-1:0]      m_ack_o;
    logic [NM-1:0]      m_err_o;
    logic [DW-1:0]      m_dat_o;

    logic               s_cyc_o;
    logic               s_stb_o;
    logic               s_we_o;
    logic [AW-1:0]      s_adr_o;
    logic [DW-1:0]      s_dat_o;
    logic [SELW-1:0]    s_sel_o;
    logic               s_ack_i;
    logic               s_err_i;
    logic [DW-1:0]      s_dat_i;

    logic [NM-1:0]      gnt_o;

    modport slave (
        input  m_cyc_i, m_stb_i, m_we_i, m_adr_i, m_dat_i, m_sel_i,
        input  s_ack_i, s_err_i, s_dat_i,
        output m_ack_o, m_err_o, m_dat_o,
        output s_cyc_o, s_stb_o, s_we_o, s_adr_o, s_dat_o, s_sel_o,
        output gnt_o
    );

    modport master (
        output m_cyc_i, m_stb_i, m_we_i, m_adr_i, m_dat_i, m_sel_i,
        output s_ack_i, s_err_i, s_dat_i,
        input  m_ack_o, m_err_o, m_dat_o,
        input  s_cyc_o, s_stb_o, s_we_o, s_adr_o, s_dat_o, s_sel_o,
        input  gnt_o
    );
endinterface

// File: rtl/wb_rr_arbiter_pick.sv
// wb_rr_pick: combinational round-robin picker. Given a request vector and
// the last granted index, returns the next winner one-hot and as an index.
// Kept standalone so other conbus arbiters can reuse it.
module wb_rr_pick
    import wb_arb_pkg::*;
#(
    parameter int NM = 3,
    parameter int IW = 2
) (
    input  logic [NM-1:0] req_i,
    input  logic [IW-1:0] last_i,
    output logic [NM-1:0] gnt_o,
    output logic [IW-1:0] idx_o,
    output logic          any_o
);

    // Scan from last+1 with wrap; one-hot is empty when nothing requests.
    always_comb begin
        idx_o = IW'(rr_next(MAX_NM'(req_i), IDX_W'(last_i), NM));
        any_o = |req_i;
        gnt_o = any_o ? (NM'(1) << idx_o) : '0;
    end

endmodule

// File: rtl/wb_rr_arbiter.sv
// wb_rr_arbiter: round-robin Wishbone arbiter, NM masters onto one shared
// port. Arbitration is per CYC: the owner keeps the bus until it drops CYC.
// Optional stall watchdog: define WB_ARB_TIMEOUT_EN to terminate a beat
// with ERR after TIMEOUT unanswered cycles.
module wb_rr_arbiter
    import wb_arb_pkg::*;
#(
    parameter int NM      = 3,
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    wb_rr_arbiter_if.slave    bus
);

    localparam int SELW = sel_w(DW);
    localparam int IW   = (NM > 1) ? $clog2(NM) : 1;
    localparam logic [IW-1:0] LAST_RST = IW'(NM - 1);

    arb_state_e     state_q, state_d;
    logic [NM-1:0]  gnt_q, gnt_d;
    logic [IW-1:0]  last_q, last_d;

    logic [NM-1:0]  pick_oh;
    logic [IW-1:0]  pick_idx;
    logic           pick_any;

    logic           own;
    logic           stb_raw;
    logic           to_fire;

    wb_rr_pick #(.NM(NM), .IW(IW)) u_pick (
        .req_i  (bus.m_cyc_i),
        .last_i (last_q),
        .gnt_o  (pick_oh),
        .idx_o  (pick_idx),
        .any_o  (pick_any)
    );

    // While owning, last_q holds the granted index, so it drives the mux.
    assign own     = (state_q == OWN);
    assign stb_raw = own & bus.m_stb_i[last_q] & bus.m_cyc_i[last_q];

`ifdef WB_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0] cnt_q, cnt_d;

    // Watchdog: count stalled beats, fire once at the limit and restart.
    always_comb begin
        to_fire = stb_raw & (cnt_q == CW'(TIMEOUT));
        cnt_d   = '0;
        if (!to_fire && stb_raw && !bus.s_ack_i && !bus.s_err_i)
            cnt_d = cnt_q + 1'b1;
    end
`else
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT != 0);
    assign to_fire        = 1'b0;
`endif

    // Next-state: grant the next requester from IDLE, release on CYC drop.
    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        last_d  = last_q;
        case (state_q)
            IDLE: begin
                if (pick_any) begin
                    state_d = OWN;
                    gnt_d   = pick_oh;
                    last_d  = pick_idx;
                end
            end
            OWN: begin
                if (!bus.m_cyc_i[last_q]) begin
                    state_d = IDLE;
                    gnt_d   = '0;
                end
            end
            default: begin
                state_d = IDLE;
                gnt_d   = '0;
            end
        endcase
    end

    // FSM state, registered grant and round-robin pointer.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            last_q  <= LAST_RST;
`ifdef WB_ARB_TIMEOUT_EN
            cnt_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            last_q  <= last_d;
`ifdef WB_ARB_TIMEOUT_EN
            cnt_q   <= cnt_d;
`endif
        end
    end

    // Shared port is a plain mux of the owner; quiet whenever not owning.
    // gnt_q is one-hot in OWN and zero in IDLE, so it gates ack/err routing.
    always_comb begin
        bus.gnt_o   = gnt_q;
        bus.m_dat_o = bus.s_dat_i;
        bus.s_cyc_o = own & bus.m_cyc_i[last_q];
        bus.s_stb_o = stb_raw & ~to_fire;
        bus.s_we_o  = own & bus.m_we_i[last_q];
        bus.s_adr_o = own ? bus.m_adr_i[lane_lsb(int'(last_q), AW) +: AW] : '0;
        bus.s_dat_o = own ? bus.m_dat_i[lane_lsb(int'(last_q), DW) +: DW] : '0;
        bus.s_sel_o = own ? bus.m_sel_i[lane_lsb(int'(last_q), SELW) +: SELW] : '0;
        bus.m_ack_o = gnt_q & {NM{bus.s_ack_i}};
        bus.m_err_o = gnt_q & {NM{bus.s_err_i | to_fire}};
    end

endmodule

// File: tb/tb_wb_rr_arbiter.sv
// tb_wb_rr_arbiter: directed vector table plus hand-written multi-cycle
// sequences for the round-robin Wishbone arbiter (NM=3, TIMEOUT=8).
module tb_wb_rr_arbiter;

    localparam int NM = 3, AW = 32, DW = 32, TIMEOUT = 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    wb_rr_arbiter_if #(.NM(NM), .AW(AW), .DW(DW)) bus ();

    wb_rr_arbiter #(.NM(NM), .AW(AW), .DW(DW), .TIMEOUT(TIMEOUT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks   = 0;
    int failures = 0;

    logic [31:0] adrs [3] = '{32'h0A0, 32'h100, 32'h2C0};

    typedef struct {
        logic [2:0]  cyc, stb;
        logic        ack;
        logic [2:0]  e_gnt;
        logic        e_cyc, e_stb, e_we;
        logic [2:0]  e_ack;
        logic [31:0] e_adr;
    } vec_t;

    vec_t tv [16];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t mk(input logic [2:0] cyc, input logic [2:0] stb, input logic ack,
                                input logic [2:0] g, input logic c, input logic s, input logic w,
                                input logic [2:0] a, input logic [31:0] adr);
        vec_t v;
        v.cyc = cyc; v.stb = stb; v.ack = ack; v.e_gnt = g; v.e_cyc = c;
        v.e_stb = s; v.e_we = w; v.e_ack = a; v.e_adr = adr;
        return v;
    endfunction

    function automatic int oh2i(input logic [2:0] v);
        int r = -1;
        for (int i = 0; i < 3; i++) if (v[i]) r = i;
        return r;
    endfunction

    task automatic idle_inputs;
        bus.m_cyc_i = '0; bus.m_stb_i = '0; bus.s_ack_i = 1'b0; bus.s_err_i = 1'b0;
    endtask

    task automatic do_reset;
        idle_inputs();
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
    endtask

    initial begin
        bus.m_adr_i = {32'h2C0, 32'h100, 32'h0A0};
        bus.m_dat_i = {32'hD2, 32'hD1, 32'hD0};
        bus.m_sel_i = {4'hC, 4'h3, 4'hF};
        bus.m_we_i  = 3'b100;
        bus.s_dat_i = 32'hCAFE0001;
        idle_inputs();

        // Reset dominates even with every master requesting.
        rst = 1'b1;
        bus.m_cyc_i = 3'b111; bus.m_stb_i = 3'b111; bus.s_ack_i = 1'b1;
        tick(); tick();
        chk("rst_gnt",   bus.gnt_o,   3'b000);
        chk("rst_s_cyc", bus.s_cyc_o, 1'b0);
        chk("rst_s_stb", bus.s_stb_o, 1'b0);
        chk("rst_m_ack", bus.m_ack_o, 3'b000);
        chk("rst_m_err", bus.m_err_o, 3'b000);
        chk("rst_s_adr", bus.s_adr_o, 32'h0);
        idle_inputs();
        rst = 1'b0;

        //            cyc     stb     ack   gnt     cyc   stb   we    ack     adr
        tv[0]  = mk(3'b010, 3'b010, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 3'b000, 32'h0);
        tv[1]  = mk(3'b010, 3'b010, 1'b0, 3'b010, 1'b1, 1'b1, 1'b0, 3'b000, 32'h100);
        tv[2]  = mk(3'b010, 3'b010, 1'b1, 3'b010, 1'b1, 1'b1, 1'b0, 3'b010, 32'h100);
        tv[3]  = mk(3'b000, 3'b000, 1'b0, 3'b010, 1'b0, 1'b0, 1'b0, 3'b000, 32'h100);
        tv[4]  = mk(3'b000, 3'b000, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 3'b000, 32'h0);
        tv[5]  = mk(3'b111, 3'b000, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 3'b000, 32'h0);
        tv[6]  = mk(3'b111, 3'b011, 1'b0, 3'b100, 1'b1, 1'b0, 1'b1, 3'b000, 32'h2C0);
        tv[7]  = mk(3'b111, 3'b111, 1'b1, 3'b100, 1'b1, 1'b1, 1'b1, 3'b100, 32'h2C0);
        tv[8]  = mk(3'b011, 3'b000, 1'b1, 3'b100, 1'b0, 1'b0, 1'b1, 3'b100, 32'h2C0);
        tv[9]  = mk(3'b011, 3'b000, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 3'b000, 32'h0);
        tv[10] = mk(3'b011, 3'b001, 1'b0, 3'b001, 1'b1, 1'b1, 1'b0, 3'b000, 32'h0A0);
        tv[11] = mk(3'b010, 3'b011, 1'b1, 3'b001, 1'b0, 1'b0, 1'b0, 3'b001, 32'h0A0);
        tv[12] = mk(3'b010, 3'b010, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 3'b000, 32'h0);
        tv[13] = mk(3'b010, 3'b111, 1'b0, 3'b010, 1'b1, 1'b1, 1'b0, 3'b000, 32'h100);
        tv[14] = mk(3'b000, 3'b000, 1'b0, 3'b010, 1'b0, 1'b0, 1'b0, 3'b000, 32'h100);
        tv[15] = mk(3'b000, 3'b000, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 3'b000, 32'h0);

        for (int i = 0; i < 16; i++) begin
            bus.m_cyc_i = tv[i].cyc; bus.m_stb_i = tv[i].stb; bus.s_ack_i = tv[i].ack;
            #3;
            chk($sformatf("v%0d_gnt", i),   bus.gnt_o,   tv[i].e_gnt);
            chk($sformatf("v%0d_s_cyc", i), bus.s_cyc_o, tv[i].e_cyc);
            chk($sformatf("v%0d_s_stb", i), bus.s_stb_o, tv[i].e_stb);
            chk($sformatf("v%0d_s_we", i),  bus.s_we_o,  tv[i].e_we);
            chk($sformatf("v%0d_m_ack", i), bus.m_ack_o, tv[i].e_ack);
            chk($sformatf("v%0d_s_adr", i), bus.s_adr_o, tv[i].e_adr);
            tick();
        end

        // All three request from reset, 4 beats each; master 0 re-requests.
        begin
            logic [2:0] cyc_v = 3'b111;
            logic [2:0] prev  = 3'b000;
            int need [3] = '{2, 1, 1};
            int beats[3] = '{0, 0, 0};
            int exp_order[4] = '{0, 1, 2, 0};
            int order[$];
            int gap = 0, leak = 0;
            bit done = 1'b0;
            do_reset();
            for (int c = 0; c < 80 && !done; c++) begin
                bus.m_cyc_i = cyc_v; bus.m_stb_i = cyc_v; bus.s_ack_i = 1'b0;
                #1;
                bus.s_ack_i = bus.s_stb_o;
                #1;
                if (bus.gnt_o != 3'b000 && prev == 3'b000) begin
                    if (order.size() > 0) chk("h1_gap", gap, 1);
                    order.push_back(oh2i(bus.gnt_o));
                    gap = 0;
                end else if (bus.gnt_o == 3'b000 && order.size() > 0) gap++;
                if ((bus.m_ack_o & ~bus.gnt_o) != 3'b000) leak++;
                if (bus.gnt_o != 3'b000 && bus.s_adr_o != adrs[oh2i(bus.gnt_o)]) leak++;
                for (int k = 0; k < 3; k++) if (bus.m_ack_o[k]) beats[k]++;
                prev = bus.gnt_o;
                tick();
                for (int k = 0; k < 3; k++) begin
                    if (cyc_v[k] && beats[k] == 4) begin
                        cyc_v[k] = 1'b0; beats[k] = 0; need[k]--;
                    end else if (!cyc_v[k] && need[k] > 0) cyc_v[k] = 1'b1;
                end
                if (cyc_v == 3'b000 && need[0] == 0 && need[1] == 0 && need[2] == 0) done = 1'b1;
            end
            chk("h1_done", done, 1'b1);
            chk("h1_grants", order.size(), 4);
            for (int i = 0; i < order.size() && i < 4; i++)
                chk($sformatf("h1_order%0d", i), order[i], exp_order[i]);
            chk("h1_leak", leak, 0);
            idle_inputs();
            tick();
        end

        // Master 0 holds 10 beats while master 2 waits.
        do_reset();
        bus.m_cyc_i = 3'b001; bus.m_stb_i = 3'b001;
        tick();
        bus.m_cyc_i = 3'b101; bus.m_stb_i = 3'b101; bus.s_ack_i = 1'b1;
        #1;
        chk("h2_sel", bus.s_sel_o, 4'hF);
        chk("h2_dat", bus.s_dat_o, 32'hD0);
        for (int b = 0; b < 10; b++) begin
            #1;
            chk($sformatf("h2_ack%0d", b), bus.m_ack_o, 3'b001);
            chk($sformatf("h2_adr%0d", b), bus.s_adr_o, 32'h0A0);
            tick();
        end
        bus.m_cyc_i = 3'b100; bus.m_stb_i = 3'b100; bus.s_ack_i = 1'b0;
        #1;
        chk("h2_drop_gnt", bus.gnt_o, 3'b001);
        chk("h2_drop_cyc", bus.s_cyc_o, 1'b0);
        tick();
        chk("h2_gap_gnt", bus.gnt_o, 3'b000);
        tick();
        chk("h2_m2_gnt", bus.gnt_o, 3'b100);
        chk("h2_m2_adr", bus.s_adr_o, 32'h2C0);
        idle_inputs();
        tick(); tick();

        // Reset mid-burst while master 1 owns; master 0 wins afterwards.
        do_reset();
        bus.m_cyc_i = 3'b010; bus.m_stb_i = 3'b010;
        tick();
        chk("h3_own_gnt", bus.gnt_o, 3'b010);
        rst = 1'b1; bus.s_ack_i = 1'b1;
        tick();
        chk("h3_rst_cyc", bus.s_cyc_o, 1'b0);
        chk("h3_rst_gnt", bus.gnt_o, 3'b000);
        chk("h3_rst_ack", bus.m_ack_o, 3'b000);
        rst = 1'b0; bus.s_ack_i = 1'b0;
        bus.m_cyc_i = 3'b111; bus.m_stb_i = 3'b111;
        #1;
        chk("h3_idle_gnt", bus.gnt_o, 3'b000);
        tick();
        chk("h3_first_gnt", bus.gnt_o, 3'b001);
        idle_inputs();
        tick(); tick();

        // Error passthrough, then a beat the slave never answers.
        do_reset();
        bus.m_cyc_i = 3'b001; bus.m_stb_i = 3'b001;
        tick();
        bus.s_err_i = 1'b1;
        #1;
        chk("h4_err_pass", bus.m_err_o, 3'b001);
        chk("h4_rd_dat", bus.m_dat_o, 32'hCAFE0001);
        tick();
        bus.s_err_i = 1'b0;
`ifdef WB_ARB_TIMEOUT_EN
        begin
            int pulses = 0, first = -1;
            for (int c = 0; c < 17; c++) begin
                #1;
                if (bus.m_err_o != 3'b000) begin
                    pulses++;
                    if (first < 0) first = c;
                    chk("h4_stb_forced", bus.s_stb_o, 1'b0);
                end
                tick();
            end
            chk("h4_pulses", pulses, 1);
            chk("h4_first", first, 8);
            #1;
            chk("h4_restart", bus.m_err_o, 3'b001);
        end
`else
        begin
            int errs = 0, stb_lo = 0;
            for (int c = 0; c < 100; c++) begin
                #1;
                if (bus.m_err_o != 3'b000) errs++;
                if (!bus.s_stb_o) stb_lo++;
                tick();
            end
            chk("h4_no_err", errs, 0);
            chk("h4_stb_held", stb_lo, 0);
        end
`endif
        idle_inputs();
        tick(); tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
